// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: serial line and received-byte outputs of the UART byte receiver
interface uart_byte_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  modport master (output rx, input data, valid, frame_err, busy);
  modport slave  (input rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver that strobes each correctly framed byte out for one cycle
module uart_byte_rx #(
  parameter int WAIT = 868
) (
  input  logic          clk,
  input  logic          reset,
  uart_byte_rx_if.slave bus
);
  localparam int             CW   = $clog2(WAIT);
  localparam logic [CW-1:0] HALF = CW'((WAIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(WAIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t        r_state;
  state_t        w_next;
  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_sh;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_ferr;
  logic          w_rx_s;
  logic          w_half_tick;
  logic          w_bit_tick;
  logic          w_valid_d;
  logic          w_ferr_d;
  logic          w_busy;
  assign w_rx_s      = r_sync2;
  assign w_half_tick = (r_state == START) && (r_cnt == HALF);
  assign w_bit_tick  = ((r_state == DATA) || (r_state == STOP)) && (r_cnt == LAST);
  // two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rx;
      r_sync2 <= r_sync1;
    end
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // bit timing counter, bit index and data shift register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_sh      <= '0;
    end else begin
      r_cnt <= ((r_state == IDLE) || (r_state == BRK) || w_half_tick || w_bit_tick) ? '0 : r_cnt + 1'b1;
      if (w_half_tick) r_bit_idx <= '0;
      else if (w_bit_tick && (r_state == DATA)) r_bit_idx <= r_bit_idx + 3'd1;
      if (w_bit_tick && (r_state == DATA)) r_sh <= {w_rx_s, r_sh[7:1]};
    end
  end
  // next-state: start is re-checked at mid-bit, stop bit decides valid vs break
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_rx_s ? IDLE : START;
      START:   w_next = w_half_tick ? (w_rx_s ? IDLE : DATA) : START;
      DATA:    w_next = (w_bit_tick && (r_bit_idx == 3'd7)) ? STOP : DATA;
      STOP:    w_next = w_bit_tick ? (w_rx_s ? IDLE : BRK) : STOP;
      BRK:     w_next = w_rx_s ? IDLE : BRK;
      default: w_next = IDLE;
    endcase
  end
  // output decode: strobes are computed here and registered for one clean cycle
  always_comb begin
    w_valid_d = (r_state == STOP) && w_bit_tick && w_rx_s;
    w_ferr_d  = (r_state == STOP) && w_bit_tick && !w_rx_s;
    w_busy    = r_state != IDLE;
  end
  // registered byte and strobes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_valid_d) r_data <= r_sh;
      r_valid <= w_valid_d;
      r_ferr  <= w_ferr_d;
    end
  end
  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: directed frames against a frame-timing scoreboard of expected strobes
module tb_uart_byte_rx;
  localparam int W = 8;
  localparam int H = (W - 1) / 2;
  typedef struct {
    int         edge_no;
    bit         is_valid;
    logic [7:0] d;
  } ev_t;
  logic clk;
  logic reset;
  int   ecount;
  int   checks;
  int   failures;
  int   vcnt;
  int   fcnt;
  int   last_ve;
  int   prev_ve;
  logic [7:0] model_data;
  ev_t  q[$];
  uart_byte_rx_if bus();
  uart_byte_rx #(.WAIT(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  // caller is at a negedge; first edge sampling the start bit is ecount+1
  task automatic send_frame(input logic [7:0] b, input bit stop, input int rst_pos, output int e0);
    logic [9:0] f;
    ev_t ev;
    f = {stop, b, 1'b0};
    e0 = ecount + 1;
    if (rst_pos < 0) begin
      ev.edge_no = e0 + 3 + H + 9 * W;
      ev.is_valid = stop;
      ev.d = b;
      q.push_back(ev);
    end
    for (int i = 0; i < 10; i++) begin
      bus.rx = f[i];
      for (int j = 0; j < W; j++) begin
        if (i == rst_pos && j == 2) reset = 1'b0;
        if (i == rst_pos && j == 5) reset = 1'b1;
        @(negedge clk);
      end
    end
  endtask
  // scoreboard compare: a strobe is due exactly when a scheduled frame ends at this edge
  initial begin
    logic ev_v;
    logic ev_f;
    forever begin
      @(posedge clk);
      #1;
      if (!reset) begin
        model_data = 8'h00;
        chk("rst_valid", bus.valid, 0);
        chk("rst_ferr", bus.frame_err, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_data", bus.data, 0);
      end else begin
        ev_v = 1'b0;
        ev_f = 1'b0;
        if (q.size() > 0 && q[0].edge_no == ecount) begin
          ev_v = q[0].is_valid;
          ev_f = !q[0].is_valid;
          if (ev_v) model_data = q[0].d;
          void'(q.pop_front());
        end
        chk("valid", bus.valid, ev_v);
        chk("frame_err", bus.frame_err, ev_f);
        chk("data", bus.data, model_data);
      end
      if (bus.valid) begin
        vcnt++;
        prev_ve = last_ve;
        last_ve = ecount;
      end
      if (bus.frame_err) fcnt++;
    end
  end
  initial begin
    int e0;
    int e1;
    int v0;
    int f0;
    int g0;
    int r0;
    ecount = 0; checks = 0; failures = 0; vcnt = 0; fcnt = 0; last_ve = 0; prev_ve = 0;
    model_data = 8'h00;
    reset = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2 * W) @(negedge clk);
    // single byte
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h55, 1'b1, -1, e0);
    chk("single_count", vcnt - v0, 1);
    chk("single_edge", last_ve - e0, 78);
    chk("single_data", bus.data, 8'h55);
    chk("single_ferr", fcnt - f0, 0);
    repeat (2 * W) @(negedge clk);
    // back-to-back
    v0 = vcnt;
    send_frame(8'hA3, 1'b1, -1, e0);
    chk("b2b_first", bus.data, 8'hA3);
    send_frame(8'h0F, 1'b1, -1, e1);
    chk("b2b_gap", last_ve - prev_ve, 80);
    chk("b2b_count", vcnt - v0, 2);
    chk("b2b_second", bus.data, 8'h0F);
    repeat (2 * W) @(negedge clk);
    // glitch
    v0 = vcnt; f0 = fcnt;
    bus.rx = 1'b0;
    g0 = ecount + 1;
    repeat (2) @(negedge clk);
    bus.rx = 1'b1;
    @(negedge clk);
    chk("glitch_busy_hi", {ecount - g0, 1'b0, bus.busy}, {32'd2, 1'b0, 1'b1});
    repeat (4) @(negedge clk);
    chk("glitch_busy_lo", bus.busy, 0);
    repeat (20 * W) @(negedge clk);
    chk("glitch_valid", vcnt - v0, 0);
    chk("glitch_ferr", fcnt - f0, 0);
    chk("glitch_data", bus.data, 8'h0F);
    // framing error then recovery
    v0 = vcnt; f0 = fcnt;
    send_frame(8'h3C, 1'b0, -1, e0);
    chk("ferr_count", fcnt - f0, 1);
    chk("ferr_valid", vcnt - v0, 0);
    chk("ferr_data", bus.data, 8'h0F);
    repeat (3 * W) @(negedge clk);
    chk("ferr_busy_low_line", bus.busy, 1);
    bus.rx = 1'b1;
    r0 = ecount + 1;
    repeat (2) @(negedge clk);
    chk("ferr_busy_hold", bus.busy, 1);
    @(negedge clk);
    chk("ferr_busy_exit", {ecount - r0, 1'b0, bus.busy}, {32'd2, 1'b0, 1'b0});
    repeat (2 * W) @(negedge clk);
    send_frame(8'h81, 1'b1, -1, e0);
    chk("after_ferr_data", bus.data, 8'h81);
    repeat (2 * W) @(negedge clk);
    // reset during data bit 4
    v0 = vcnt; f0 = fcnt;
    send_frame(8'hFF, 1'b1, 5, e0);
    chk("abort_valid", vcnt - v0, 0);
    chk("abort_ferr", fcnt - f0, 0);
    chk("abort_data", bus.data, 8'h00);
    repeat (2 * W) @(negedge clk);
    send_frame(8'h42, 1'b1, -1, e0);
    chk("post_reset_data", bus.data, 8'h42);
    chk("post_reset_count", vcnt - v0, 1);
    repeat (2 * W) @(negedge clk);
    chk("pending_events", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

Serial-to-parallel UART receiver for 8N1 frames: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. It is the receive end of the same serial format that the `mother_board` bench drives onto `uart_rx`. It sits inside `mother_board` behind the `uart_rx` pin and hands each received byte to the core as a one-cycle strobe. The bit period is `WAIT` clock cycles, the same `WAIT` used by the transmitter and the benches.

## Interface
- `WAIT`, default 868, clock cycles per bit (100 MHz / 115200). Legal range is `WAIT >= 4`.
- `clk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  asynchronous, active-low reset (asserted when 0)
- `rx`  input  1  asynchronous serial line; idles high
- `data`  output  8  last correctly framed byte; held until the next one
- `valid`  output  1  one-cycle pulse when `data` is updated
- `frame_err`  output  1  one-cycle pulse when the stop bit is sampled low
- `busy`  output  1  high in any state other than IDLE

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer to give `rx_s`. Both flops reset to 1. All decisions use `rx_s` only.
- **Counter:** `cnt` has width `$clog2(WAIT)`. `bit_idx` has 3 bits. The shift register `sh` has 8 bits.
- **Half-bit constant:** `H = (WAIT-1)/2`, integer division.
- **States:** IDLE, START, DATA, STOP, BREAK.
  - **IDLE:** if `rx_s==0`, go to START with `cnt=0`.
  - **START:** if `cnt!=H`, increment `cnt`. If `cnt==H` and `rx_s==0`, go to DATA with `cnt=0`, `bit_idx=0`. If `cnt==H` and `rx_s==1`, treat it as a glitch and return to IDLE with no output.
  - **DATA:** if `cnt!=WAIT-1`, increment `cnt`. If `cnt==WAIT-1`, set `sh={rx_s, sh[7:1]}` and `cnt=0`. If `bit_idx==7`, go to STOP; otherwise increment `bit_idx`.
  - **STOP:** if `cnt!=WAIT-1`, increment `cnt`. If `cnt==WAIT-1` and `rx_s==1`, set `data<=sh`, pulse `valid`, and go to IDLE. If `cnt==WAIT-1` and `rx_s==0`, pulse `frame_err`, leave `data` unchanged, and go to BREAK.
  - **BREAK:** stay until `rx_s==1`, then go to IDLE. A held-low line (break) never produces `valid`.
- **Back-to-back frames:** STOP returns to IDLE at mid-stop-bit, so a start bit directly after the stop bit is detected.
- **Flow control:** none. The consumer must take `data` on `valid` or tolerate it being overwritten by the next frame.
- **Reset values:**
  - `data=0`, `valid=0`, `frame_err=0`, `busy=0`
  - state IDLE, `cnt=0`, `bit_idx=0`, `sh=0`, synchronizer flops 1
- **Reset mid-frame:** asserting reset during a frame aborts it with no `valid` or `frame_err`. After release, the block waits in IDLE. If the line is still low mid-frame, a false start may be detected; it is then rejected by the START check or flagged at STOP.

## Timing
- **Edge numbering:** let e0 be the first `clk` edge that samples `rx==0` into flop 1.
  - `rx_s` is 0 after e1.
  - IDLE→START occurs at e2.
  - START→DATA occurs at e(3+H).
  - Data bit n (0..7) is sampled at e(3+H+(n+1)·WAIT).
  - The stop bit is sampled at e(3+H+9·WAIT). `valid` or `frame_err` is high for exactly the cycle after that edge.
- **Frame length:** one frame lasts `10·WAIT` cycles at the line. The receiver is back in IDLE about `WAIT/2` cycles before the stop bit ends.
- **Glitch rejection:** a low pulse shorter than about `H` cycles returns to IDLE at e(3+H).
- `valid` and `frame_err` are never high in the same cycle.
- `busy` rises after e2. It falls in the same cycle `valid` rises, or when BREAK exits.
- `data` changes only on the edge that raises `valid`.

## Test plan
All scenarios use `WAIT=8` (H=3) and the bench's bit-banging task at `WAIT·CLOCK_PERIOD` per bit.
- **Single byte:** send 0x55 → exactly one `valid` pulse, at e(3+3+72)=e78 relative to the start edge; `data==8'h55`; `frame_err` stays 0.
- **Back-to-back:** send 0xA3 then 0x0F with no idle gap → two `valid` pulses 80 cycles apart; `data` is 0xA3, then 0x0F.
- **Glitch:** drive `rx` low for 2 cycles, then high for 20·WAIT → `busy` pulses briefly; no `valid`; no `frame_err`; `data` unchanged.
- **Framing error:** send 0x3C with the stop bit 0, hold low for 3·WAIT, then high → one `frame_err` pulse; no `valid`; `busy` stays high until `rx_s` returns to 1. A following 0x81 is then received correctly.
- **Reset mid-frame:** assert reset (0) for 3 cycles during data bit 4 of 0xFF, then let the frame finish → all outputs read their reset values during reset; no `valid` for the aborted frame. The next clean 0x42 yields `valid` with `data==8'h42`.
